elastic_pipe_reg: RTL
=====================

// Module: elastic_pipe_reg
// PURPOSE
//  Parametrised valid/ready pipeline register: successor to the enable-only DW pipe wrapper.
//  DEPTH stages, each a 2-entry skid buffer, so every ready path is registered.
//  Back-pressure never drops or duplicates data; a synchronous flush empties all stages.
//  Sits between rasterizer pipeline units (bbox -> sample test -> hash) where stalls propagate.
// PARAMETERS
//  WIDTH   64  payload bit width
//  DEPTH   2   number of skid stages; 0 = combinational pass-through
//  CNT_W   $clog2(2*DEPTH+1) (derived, min 1)  width of occupancy count
// PORTS
//  clk        in   1      clock; all state updates on rising edge
//  reset      in   1      synchronous, active-high reset
//  flush      in   1      synchronous: discard all held entries
//  in_valid   in   1      upstream payload valid
//  in_data    in   WIDTH  upstream payload
//  in_ready   out  1      stage 0 can accept; registered (DEPTH>0)
//  out_valid  out  1      last stage holds a payload
//  out_data   out  WIDTH  last stage payload
//  out_ready  in   1      downstream accepts
//  count      out  CNT_W  total entries held across all stages (0..2*DEPTH)
// BEHAVIOUR
//  - Transfer rules: input transfer = in_valid & in_ready; output transfer = out_valid & out_ready.
//  - Stage k: main reg (M) + skid reg (S).
//    - Stage k output = M. ready_k (to stage k-1) = !S_valid, registered.
//  - Stage k, per cycle:
//    - Downstream takes M and S valid: S moves into M, S cleared.
//    - Downstream takes M, S empty: M loads the incoming item, or clears if none.
//    - M empty: the incoming item loads into M.
//    - M held (downstream stalled) and an item arrives: item loads into S.
//  - Ordering strictly FIFO; M always older than S.
//  - Latency: empty pipe with out_ready=1 -> in_data at edge t appears on out_data after edge t+DEPTH-1
//    (out_valid high DEPTH cycles after in_valid sampled). Throughput 1 item/cycle when unstalled.
//  - Stall: out_ready=0 -> out_valid/out_data hold stable until accepted (AXI-style).
//    - Pipe absorbs up to 2*DEPTH items, then in_ready=0.
//    - in_ready falls one cycle after stage-0 S fills; no item accepted while in_ready=0.
//  - Simultaneous input and output transfer when full: none possible, since in_ready=0.
//    - in_ready returns to 1 the cycle after stage-0 S drains.
//  - flush:
//    - All M/S valids cleared at the edge; count=0, in_ready=1, out_valid=0 the next cycle.
//    - An input offered in the flush cycle is discarded.
//    - An output transfer in the flush cycle still counts as consumed.
//  - flush and reset identical in effect on valids; reset also zeros all data regs.
//  - Reset values: out_valid=0, out_data=0, in_ready=1, count=0. Reset mid-stream drops all entries.
//  - count: incremented on input transfer, decremented on output transfer.
//    - Both in one cycle: unchanged. Flush/reset: 0. Never exceeds 2*DEPTH.
//  - DEPTH=0:
//    - out_valid = in_valid & ~reset; out_data = in_data & ~{WIDTH{reset}}.
//    - in_ready = out_ready; count = 0; flush ignored.
//  - in_valid may drop without transfer; it is not required to hold.
// TESTING
//  1. WIDTH=64, DEPTH=2, out_ready=1, feed 0x1..0x10 back-to-back
//     -> out 0x1..0x10 in order, first out_valid 2 cycles after first in_valid, 1/cycle.
//  2. out_ready=0, in_valid=1 continuous -> exactly 4 accepted; count=4; in_ready=0; out_data=0x1 stable.
//  3. From test 2, out_ready=1 for 1 cycle -> 0x1 consumed, count=3.
//     in_ready=1 after stage-0 skid drains; no loss or duplicate.
//  4. Random in_valid/out_ready (50% each), 10k items -> scoreboard order match.
//     count == accepted - consumed every cycle.
//  5. Pipe holds 3 items, assert flush with in_valid=1 -> next cycle count=0, out_valid=0, in_ready=1.
//     Flushed items never appear.
//  6. reset mid-stream -> outputs 0/1/0 per reset values next cycle.
//     DEPTH=0 build: out mirrors in combinationally, zeroed in reset.

Source files
------------

// File: rtl/elastic_pipe_reg.sv
// Valid/ready pipeline of DEPTH two-entry skid stages; every ready is a flop output.
// DEPTH cycles in->out, 1 item/cycle unstalled; stalls absorb up to 2*DEPTH items, never drop or duplicate.
module elastic_pipe_reg #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2,
  parameter int CNT_W = (DEPTH == 0) ? 1 : $clog2(2 * DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [CNT_W-1:0] count
);

  if (DEPTH == 0) begin : g_pass
    logic pass_unused;
    assign pass_unused = ^{clk, flush};
    assign out_valid   = in_valid & ~reset;
    assign out_data    = in_data & ~{WIDTH{reset}};
    assign in_ready    = out_ready;
    assign count       = '0;
  end else begin : g_pipe
    // Chain index k is the input side of stage k; index DEPTH is the pipe output.
    logic [DEPTH:0]   vld_c;
    logic [DEPTH:0]   rdy_c;
    logic [WIDTH-1:0] dat_c [DEPTH+1];
    logic [CNT_W-1:0] count_q, count_d;
    logic             in_xfer, out_xfer;

    assign vld_c[0]     = in_valid;
    assign dat_c[0]     = in_data;
    assign rdy_c[DEPTH] = out_ready;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
      logic             m_vld_q, m_vld_d, s_vld_q, s_vld_d;
      logic [WIDTH-1:0] m_dat_q, m_dat_d, s_dat_q, s_dat_d;
      logic             up_xfer, dn_take;

      assign up_xfer = vld_c[k] & ~s_vld_q;
      assign dn_take = m_vld_q & rdy_c[k+1];

      always_comb begin
        m_vld_d = m_vld_q;
        m_dat_d = m_dat_q;
        s_vld_d = s_vld_q;
        s_dat_d = s_dat_q;
        if (dn_take && s_vld_q) begin
          m_dat_d = s_dat_q;
          s_vld_d = 1'b0;
        end else if (dn_take || !m_vld_q) begin
          m_vld_d = up_xfer;
          if (up_xfer) m_dat_d = dat_c[k];
        end else if (up_xfer) begin
          s_vld_d = 1'b1;
          s_dat_d = dat_c[k];
        end
        if (flush) begin
          m_vld_d = 1'b0;
          s_vld_d = 1'b0;
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          m_vld_q <= 1'b0;
          s_vld_q <= 1'b0;
          m_dat_q <= '0;
          s_dat_q <= '0;
        end else begin
          m_vld_q <= m_vld_d;
          s_vld_q <= s_vld_d;
          m_dat_q <= m_dat_d;
          s_dat_q <= s_dat_d;
        end
      end

      assign vld_c[k+1] = m_vld_q;
      assign dat_c[k+1] = m_dat_q;
      assign rdy_c[k]   = ~s_vld_q;
    end

    assign in_ready  = rdy_c[0];
    assign out_valid = vld_c[DEPTH];
    assign out_data  = dat_c[DEPTH];

    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready;

    always_comb begin
      count_d = count_q + CNT_W'(in_xfer) - CNT_W'(out_xfer);
      if (flush) count_d = '0;
    end

    always_ff @(posedge clk) begin
      if (reset) count_q <= '0;
      else       count_q <= count_d;
    end

    assign count = count_q;
  end

endmodule
